// File: rtl/pixel_pkg.sv
// Shared pixel-path definitions, used by the clipper and the upstream MAC array.
//   - DEF_* : default sample/pixel geometry.
//   - pix_max(out_w)          : largest unsigned pixel value, 2^out_w - 1.
//   - round_const(frac_shift) : half-LSB constant added for round-half-up.
package pixel_pkg;

    localparam int DEF_IN_W       = 20;
    localparam int DEF_FRAC_SHIFT = 7;
    localparam int DEF_OUT_W      = 8;
    localparam int DEF_CHANNELS   = 3;
    localparam int DEF_CNT_W      = 16;

    function automatic int pix_max(input int out_w);
        return (1 << out_w) - 1;
    endfunction

    function automatic int round_const(input int frac_shift);
        return 1 << (frac_shift - 1);
    endfunction

endpackage

// File: rtl/pixel_clip_lane.sv
// One channel of the clipper, purely combinational, split across the two
// pipeline stages of the parent:
//   sample, round_en -> shifted   : S1 half (sign-extend, optional round, >>>)
//   shifted_q        -> pix,hi,lo : S2 half (clamp to 0..2^OUT_W-1 with flags)
// Ports:
//   sample    in  IN_W            signed two's-complement filter result
//   round_en  in  1               1 = round half up, 0 = truncate
//   shifted   out IN_W-FRAC_SHIFT+1  shifted value, to the S1 register
//   shifted_q in  IN_W-FRAC_SHIFT+1  registered shifted value from S1
//   pix       out OUT_W           clamped unsigned pixel
//   hi / lo   out 1               sample was clamped to max / to zero
module pixel_clip_lane
    import pixel_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic [IN_W-1:0]                sample,
    input  logic                           round_en,
    output logic signed [IN_W-FRAC_SHIFT:0] shifted,
    input  logic signed [IN_W-FRAC_SHIFT:0] shifted_q,
    output logic [OUT_W-1:0]               pix,
    output logic                           hi,
    output logic                           lo
);

    localparam int EXT_W = IN_W + 1;
    localparam int SH_W  = IN_W + 1 - FRAC_SHIFT;
    // Compare width must hold both the shifted value and +PIX_MAX as signed.
    localparam int CMP_W = (SH_W > OUT_W + 1) ? SH_W : OUT_W + 2;

    localparam logic signed [EXT_W-1:0] RND   = EXT_W'(round_const(FRAC_SHIFT));
    localparam logic signed [CMP_W-1:0] MAX_S = CMP_W'(pix_max(OUT_W));

    logic signed [EXT_W-1:0] sum;
    logic signed [CMP_W-1:0] v;

    // The extra sign bit keeps max-positive + RND from wrapping negative.
    always_comb begin
        sum = {sample[IN_W-1], sample};
        if (round_en) begin
            sum = sum + RND;
        end
        shifted = SH_W'(sum >>> FRAC_SHIFT);
    end

    // NOTE: every output gets a default before the if/else so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        v   = CMP_W'(shifted_q);
        lo  = 1'b0;
        hi  = 1'b0;
        pix = v[OUT_W-1:0];
        if (v < 0) begin
            lo  = 1'b1;
            pix = '0;
        end else if (v > MAX_S) begin
            hi  = 1'b1;
            pix = '1;
        end
    end

endmodule

// File: rtl/pixel_clip_pipe.sv
// Multi-channel pipelined pixel clipper on a valid/ready stream.
// S1 registers the rounded/shifted samples, S2 registers the clamped pixels
// and drives the outputs. All stages advance together whenever the output
// register is empty or being drained (adv), so in_ready is combinational.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_data               CHANNELS x IN_W signed samples, ch c at [c*IN_W +: IN_W]
//   in_last               end-of-line marker, travels with the beat
//   round_en              per-beat rounding mode, consumed with the beat
//   out_valid/out_ready   output handshake
//   out_data              CHANNELS x OUT_W pixels, ch c at [c*OUT_W +: OUT_W]
//   out_last              in_last of the beat on out_data
//   clr_stats             clears both counters (wins over a same-cycle update)
//   sat_hi_cnt/sat_lo_cnt saturating counts of samples clamped to max / zero
module pixel_clip_pipe
    import pixel_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*IN_W-1:0]  in_data,
    input  logic                      in_last,
    input  logic                      round_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*OUT_W-1:0] out_data,
    output logic                      out_last,
    input  logic                      clr_stats,
    output logic [CNT_W-1:0]          sat_hi_cnt,
    output logic [CNT_W-1:0]          sat_lo_cnt
);

    localparam int SH_W  = IN_W + 1 - FRAC_SHIFT;
    localparam int ADD_W = $clog2(CHANNELS + 1);
    localparam int SUM_W = CNT_W + ADD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                   adv;
    logic                   out_hs;
    logic                   s1_valid;
    logic                   s1_last;
    logic signed [SH_W-1:0] sh_d  [CHANNELS];
    logic signed [SH_W-1:0] s1_sh [CHANNELS];
    logic [OUT_W-1:0]       pix_d [CHANNELS];
    logic [CHANNELS-1:0]    hi_d;
    logic [CHANNELS-1:0]    lo_d;
    logic [CHANNELS-1:0]    s2_hi;
    logic [CHANNELS-1:0]    s2_lo;
    logic [ADD_W-1:0]       hi_add;
    logic [ADD_W-1:0]       lo_add;
    logic [SUM_W-1:0]       hi_sum;
    logic [SUM_W-1:0]       lo_sum;

    // The only stall source is a full output register that is not taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_hs   = out_valid && out_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pixel_clip_lane #(
            .IN_W       (IN_W),
            .FRAC_SHIFT (FRAC_SHIFT),
            .OUT_W      (OUT_W)
        ) u_lane (
            .sample    (in_data[c*IN_W +: IN_W]),
            .round_en  (round_en),
            .shifted   (sh_d[c]),
            .shifted_q (s1_sh[c]),
            .pix       (pix_d[c]),
            .hi        (hi_d[c]),
            .lo        (lo_d[c])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so S2 always takes the pre-edge S1 contents.
    // NOTE: the per-channel S1 array is a handful of flops, not a RAM, so it is safe and cheap to reset with everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                s1_sh[c] <= '0;
            end
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            s2_hi     <= '0;
            s2_lo     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last <= in_last;
                for (int c = 0; c < CHANNELS; c++) begin
                    s1_sh[c] <= sh_d[c];
                end
            end
            // A bubble in S1 still moves into S2; its stale flags are never
            // counted because counting requires out_valid.
            out_valid <= s1_valid;
            out_last  <= s1_last;
            s2_hi     <= hi_d;
            s2_lo     <= lo_d;
            for (int c = 0; c < CHANNELS; c++) begin
                out_data[c*OUT_W +: OUT_W] <= pix_d[c];
            end
        end
    end

    // Per-beat clip population counts and the widened counter sums.
    always_comb begin
        hi_add = '0;
        lo_add = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hi_add = hi_add + ADD_W'(s2_hi[c]);
            lo_add = lo_add + ADD_W'(s2_lo[c]);
        end
        hi_sum = SUM_W'(sat_hi_cnt) + SUM_W'(hi_add);
        lo_sum = SUM_W'(sat_lo_cnt) + SUM_W'(lo_add);
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sat_hi_cnt <= '0;
            sat_lo_cnt <= '0;
        end else if (out_hs) begin
            sat_hi_cnt <= (hi_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : hi_sum[CNT_W-1:0];
            sat_lo_cnt <= (lo_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : lo_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pixel_clip_pipe.sv
// Self-checking bench for pixel_clip_pipe. Two instances share all inputs:
// dut (CNT_W=16) and dut4 (CNT_W=4, for counter saturation). A negedge
// monitor holds a scoreboard of expected beats and model counters.
module tb_pixel_clip_pipe;

    localparam int IN_W  = 20;
    localparam int FS    = 7;
    localparam int OUT_W = 8;
    localparam int CH    = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [CH*IN_W-1:0]     in_data = '0;
    logic                   in_last = 1'b0;
    logic                   round_en = 1'b0;
    logic                   out_ready = 1'b1;
    logic                   clr_stats = 1'b0;
    logic                   in_ready, in_ready4;
    logic                   out_valid, out_valid4;
    logic [CH*OUT_W-1:0]    out_data, out_data4;
    logic                   out_last, out_last4;
    logic [15:0]            sat_hi_cnt, sat_lo_cnt;
    logic [3:0]             hi4, lo4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CH*OUT_W-1:0] data;
        logic                last;
        int                  nhi;
        int                  nlo;
    } beat_t;

    beat_t      q[$];
    logic [7:0] cap[$];
    bit         cap_en = 1'b0;
    bit         mon_en = 1'b0;
    int         m_hi = 0, m_lo = 0, m_hi4 = 0, m_lo4 = 0;

    pixel_clip_pipe #(.IN_W(IN_W), .FRAC_SHIFT(FS), .OUT_W(OUT_W), .CHANNELS(CH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .round_en(round_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .clr_stats(clr_stats),
        .sat_hi_cnt(sat_hi_cnt), .sat_lo_cnt(sat_lo_cnt)
    );

    pixel_clip_pipe #(.IN_W(IN_W), .FRAC_SHIFT(FS), .OUT_W(OUT_W), .CHANNELS(CH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .in_last(in_last), .round_en(round_en), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_last(out_last4), .clr_stats(clr_stats),
        .sat_hi_cnt(hi4), .sat_lo_cnt(lo4)
    );

    always #5 clk = ~clk;

    // Reference: pixel = clamp(floor((x + r*2^(FS-1)) / 2^FS), 0, 255).
    function automatic beat_t ref_beat(input logic [CH*IN_W-1:0] d, input logic r, input logic l);
        beat_t         b;
        logic [IN_W-1:0] raw;
        int            x, v, pix;
        b.data = '0;
        b.last = l;
        b.nhi  = 0;
        b.nlo  = 0;
        for (int c = 0; c < CH; c++) begin
            raw = d[c*IN_W +: IN_W];
            x   = int'($signed(raw));
            v   = x + (r ? (1 << (FS - 1)) : 0);
            v   = (v >= 0) ? (v / (1 << FS)) : -((-v + (1 << FS) - 1) / (1 << FS));
            if (v < 0) begin
                pix = 0;
                b.nlo++;
            end else if (v > 255) begin
                pix = 255;
                b.nhi++;
            end else begin
                pix = v;
            end
            b.data[c*OUT_W +: OUT_W] = OUT_W'(pix);
        end
        return b;
    endfunction

    function automatic logic [CH*IN_W-1:0] pack3(input int a, input int b, input int c);
        logic [CH*IN_W-1:0] d;
        d[0*IN_W +: IN_W] = IN_W'(a);
        d[1*IN_W +: IN_W] = IN_W'(b);
        d[2*IN_W +: IN_W] = IN_W'(c);
        return d;
    endfunction

    function automatic int rand_sample();
        int x;
        x = $urandom;
        return x >>> (32 - IN_W);
    endfunction

    // Scoreboard monitor: all inputs and outputs are stable at negedge and
    // describe what the next rising edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            beat_t e;
            int    nh, nl;
            nh = 0;
            nl = 0;
            total++;
            if (sat_hi_cnt !== 16'(m_hi) || sat_lo_cnt !== 16'(m_lo)) begin
                bad++;
                $display("FAIL cnt16: got hi=%0d lo=%0d want hi=%0d lo=%0d", sat_hi_cnt, sat_lo_cnt, m_hi, m_lo);
            end
            total++;
            if (hi4 !== 4'(m_hi4) || lo4 !== 4'(m_lo4)) begin
                bad++;
                $display("FAIL cnt4: got hi=%0d lo=%0d want hi=%0d lo=%0d", hi4, lo4, m_hi4, m_lo4);
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got data=%h want no beat", out_data);
                end else begin
                    e = q.pop_front();
                    nh = e.nhi;
                    nl = e.nlo;
                    if (out_data !== e.data || out_last !== e.last || out_data4 !== e.data) begin
                        bad++;
                        $display("FAIL beat: got data=%h last=%b (cnt4 dut %h) want data=%h last=%b",
                                 out_data, out_last, out_data4, e.data, e.last);
                    end
                    if (cap_en) cap.push_back(out_data[7:0]);
                end
            end
            if (rst || clr_stats) begin
                m_hi = 0; m_lo = 0; m_hi4 = 0; m_lo4 = 0;
            end else begin
                m_hi  = (m_hi + nh > 65535) ? 65535 : m_hi + nh;
                m_lo  = (m_lo + nl > 65535) ? 65535 : m_lo + nl;
                m_hi4 = (m_hi4 + nh > 15) ? 15 : m_hi4 + nh;
                m_lo4 = (m_lo4 + nl > 15) ? 15 : m_lo4 + nl;
            end
            if (rst) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                q.push_back(ref_beat(in_data, round_en, in_last));
            end
        end
    end

    // Present one beat and hold it until accepted; returns 1 time unit after
    // the accepting edge with in_valid still high (caller drops it or sends on).
    task automatic send(input logic [CH*IN_W-1:0] d, input logic r, input logic l);
        bit hs;
        hs = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        round_en = r;
        in_last  = l;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles want acceptance");
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = (q.size() == 0) && !out_valid;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain: got %0d beats outstanding want 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            sat_hi_cnt !== 16'd0 || sat_lo_cnt !== 16'd0 || hi4 !== 4'd0 || lo4 !== 4'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got ov=%b od=%h ol=%b hi=%0d lo=%0d ir=%b want 0/0/0/0/0/1",
                     out_valid, out_data, out_last, sat_hi_cnt, sat_lo_cnt, in_ready);
        end
        q.delete();
        m_hi = 0; m_lo = 0; m_hi4 = 0; m_lo4 = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(pack3(1000, -5, 40000), 1'b0, 1'b0);
        idle_in();
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== {8'd255, 8'd0, 8'd7}) begin
            bad++;
            $display("FAIL basic_latency: got ov=%b data=%h want ov=1 data=ff0007", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        total++;
        if (sat_lo_cnt !== 16'd1 || sat_hi_cnt !== 16'd1) begin
            bad++;
            $display("FAIL basic_counts: got hi=%0d lo=%0d want hi=1 lo=1", sat_hi_cnt, sat_lo_cnt);
        end
        drain();
    endtask

    task automatic test_round();
        int          vals[4] = '{63, 64, 32703, 32704};
        logic [7:0]  want[4] = '{8'd0, 8'd1, 8'd255, 8'd255};
        pulse_clr();
        cap.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 4; i++) send(pack3(vals[i], 0, 0), 1'b1, 1'b0);
        idle_in();
        drain();
        cap_en = 1'b0;
        total++;
        if (cap.size() != 4) begin
            bad++;
            $display("FAIL round_count: got %0d beats want 4", cap.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (cap[i] !== want[i]) begin
                    bad++;
                    $display("FAIL round_pix%0d: got %0d want %0d", i, cap[i], want[i]);
                end
            end
        end
        total++;
        if (sat_hi_cnt !== 16'd1 || sat_lo_cnt !== 16'd0) begin
            bad++;
            $display("FAIL round_counts: got hi=%0d lo=%0d want hi=1 lo=0", sat_hi_cnt, sat_lo_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(pack3(rand_sample(), rand_sample(), rand_sample()), 1'($urandom_range(0, 1)), i == 9);
                idle_in();
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    total++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_ready: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_saturation();
        pulse_clr();
        for (int i = 0; i < 6; i++) send(pack3(200000, 150000, 100000), 1'b0, 1'b0);
        idle_in();
        drain();
        total++;
        if (hi4 !== 4'd15 || sat_hi_cnt !== 16'd18 || lo4 !== 4'd0) begin
            bad++;
            $display("FAIL saturation: got hi4=%0d hi16=%0d lo4=%0d want 15/18/0", hi4, sat_hi_cnt, lo4);
        end
    endtask

    task automatic test_clear();
        send(pack3(-1000, -1000, 500000), 1'b0, 1'b0);
        idle_in();
        @(posedge clk);
        #1;
        clr_stats = 1'b1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL clear_setup: got out_valid=%b want 1", out_valid);
        end
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        total++;
        if (sat_hi_cnt !== 16'd0 || sat_lo_cnt !== 16'd0 || hi4 !== 4'd0) begin
            bad++;
            $display("FAIL clear_priority: got hi=%0d lo=%0d hi4=%0d want 0", sat_hi_cnt, sat_lo_cnt, hi4);
        end
        drain();
    endtask

    task automatic test_reset_in_flight();
        send(pack3(-7000, 0, 0), 1'b0, 1'b0);
        idle_in();
        drain();
        out_ready = 1'b0;
        send(pack3(1000, 2000, 3000), 1'b0, 1'b0);
        send(pack3(4000, 5000, 6000), 1'b1, 1'b1);
        idle_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || sat_hi_cnt !== 16'd0 || sat_lo_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_flight: got ov=%b hi=%0d lo=%0d want 0/0/0", out_valid, sat_hi_cnt, sat_lo_cnt);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready: got in_ready=%b want 1", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_stale: got out_valid=1 data=%h want no beat", out_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        pulse_clr();
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        idle_in();
                        @(posedge clk);
                        #1;
                    end
                    send(pack3(rand_sample(), rand_sample(), rand_sample()),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
                end
                idle_in();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_reset_in_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_clip_pipe.md
Name: pixel_clip_pipe

Overview:
- Multi-channel, pipelined successor to the single-pixel combinational clipper.
- Takes CHANNELS signed fixed-point filter results per beat, rounds or truncates them by FRAC_SHIFT, and clamps each to unsigned OUT_W pixels.
- Sits between the interpolation MAC array and the output pixel packer, on a valid/ready stream with end-of-line marking.
- Keeps saturating counters of clipped samples for tuning the filter coefficients.

Parameters:
- IN_W, 20: width of each signed two's-complement input sample.
- FRAC_SHIFT, 7: fractional bits removed (divide by 2^FRAC_SHIFT); legal range 1..IN_W-2.
- OUT_W, 8: width of each unsigned output pixel; max value 2^OUT_W-1.
- CHANNELS, 3: samples per beat (e.g. R, G, B).
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  CHANNELS*IN_W  channel c occupies bits [c*IN_W +: IN_W].
- in_last  in  1  last beat of a line; travels with the data.
- round_en  in  1  per-beat mode: 1 = round half up, 0 = truncate; captured with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  CHANNELS*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W].
- out_last  out  1  delayed in_last.
- clr_stats  in  1  synchronous clear of both counters.
- sat_hi_cnt  out  CNT_W  count of samples clamped to max.
- sat_lo_cnt  out  CNT_W  count of samples clamped to 0.

Behaviour:
- Reset:
  - Both stage valid flags, out_valid, out_data, out_last, sat_hi_cnt and sat_lo_cnt are 0.
  - in_ready is 1 in the cycle after rst deasserts.
  - rst mid-stream discards all in-flight beats; nothing is emitted afterwards.
- Pipeline:
  - Two register stages, S1 (round/shift) and S2 (clamp, drives the outputs).
  - Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - On adv: S1 <= input beat when in_valid, else bubble; S2 <= S1.
  - Latency is 2 cycles from input handshake to out_valid with no stall.
  - Throughput is 1 beat/cycle while out_ready is high.
- Stall: while out_valid && !out_ready, all stage registers and outputs hold unchanged and in_ready = 0.
- Bubbles:
  - An S1 bubble advancing into S2 with out_ready high drops out_valid.
  - A bubble must not block a subsequent beat.
- Per-channel arithmetic, in S1:
  - Sign-extend the sample to IN_W+1 bits.
  - If the captured round_en = 1, add 2^(FRAC_SHIFT-1).
  - Arithmetic shift right by FRAC_SHIFT.
  - The extra bit guarantees no overflow; e.g. the most positive input plus the rounding constant stays positive.
- Clamp, in S2: for shifted value v:
  - v < 0 gives 0 and flags lo.
  - v > 2^OUT_W-1 gives 2^OUT_W-1 and flags hi.
  - Otherwise the output is v[OUT_W-1:0].
  - Exactly 0 or exactly max is not a clip.
- Counters:
  - Updated only on output handshake (out_valid && out_ready).
  - Each adds the number of channels flagged in that beat (0..CHANNELS).
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_stats has priority: a clear in the same cycle as a handshake yields 0, and that beat's flags are lost.
- out_last follows its beat exactly, including through stalls.

Decomposition:
- Shared package pixel_pkg holds:
  - localparam PIX_MAX(OUT_W) helper.
  - Rounding-constant function.
  - Defaults IN_W=20, FRAC_SHIFT=7, OUT_W=8, shared with the MAC array.
- One natural sub-module, pixel_clip_lane: combinational per-channel shift/round/clamp producing the value plus hi/lo flags.
  - The top instantiates CHANNELS lanes via generate.
  - The top owns the handshake, pipeline registers and counters.

Test Plan:
- Defaults, round_en=0, out_ready=1, ch0=1000, ch1=-5, ch2=40000 -> 2 cycles later out_data ch0=7, ch1=0, ch2=255; sat_lo_cnt=1, sat_hi_cnt=1.
- round_en=1, samples 63/64/32703/32704 on ch0 across 4 beats -> outputs 0/1/255/255, with 32704 counted as hi (rounds to 256) and 32703 not (rounds to 255).
- Back-to-back 10 beats with out_ready held low on cycles 4-6:
  - in_ready is low during the stall.
  - No beat is lost or duplicated; output order matches input.
  - out_last matches the beat tagged in_last (beat 9).
- Counter saturation with CNT_W=4: 6 beats each clipping all 3 channels high -> sat_hi_cnt sticks at 15.
- clr_stats asserted in the same cycle as a clipping handshake -> counter reads 0 next cycle.
- rst asserted while 2 beats are in flight -> out_valid=0 the next cycle, counters 0, no stale beat emitted.
